// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue path: ALUCC codes, ALUOp classes, funct3 values
// and the beat record carried from ID into EX.
package alu_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int OPCODE_LENGTH = 4;
    localparam int REG_ADDR_W    = 5;

    localparam logic [3:0] ALUCC_AND = 4'b0000;
    localparam logic [3:0] ALUCC_OR  = 4'b0001;
    localparam logic [3:0] ALUCC_ADD = 4'b0010;
    localparam logic [3:0] ALUCC_SUB = 4'b0110;

    localparam logic [1:0] ALUOP_LDST = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_I    = 2'b11;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    srca;
        logic [DATA_WIDTH-1:0]    srcb;
        logic [OPCODE_LENGTH-1:0] alucc;
        logic [REG_ADDR_W-1:0]    rd;
        logic                     reg_write;
        logic                     illegal;
    } issue_beat_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: maps ALUOp/funct3/funct7[5] to the ALUCC code.
// Unsupported combinations fall back to ADD and raise illegal.
module alu_ctrl_decode
    import alu_pkg::*;
#(
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [1:0]               i_alu_op,
    input  logic [2:0]               i_funct3,
    input  logic                     i_funct7_b5,
    output logic [OPCODE_LENGTH-1:0] o_alucc,
    output logic                     o_illegal
);

    always_comb begin
        o_alucc   = OPCODE_LENGTH'(ALUCC_ADD);
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_LDST: o_alucc = OPCODE_LENGTH'(ALUCC_ADD);
            ALUOP_BR:   o_alucc = OPCODE_LENGTH'(ALUCC_SUB);
            ALUOP_R: begin
                case (i_funct3)
                    F3_ADD:  o_alucc = i_funct7_b5 ? OPCODE_LENGTH'(ALUCC_SUB)
                                                   : OPCODE_LENGTH'(ALUCC_ADD);
                    F3_AND:  o_alucc = OPCODE_LENGTH'(ALUCC_AND);
                    F3_OR:   o_alucc = OPCODE_LENGTH'(ALUCC_OR);
                    default: o_illegal = 1'b1;
                endcase
            end
            ALUOP_I: begin
                // Immediate forms have no SUB; funct7 is part of the immediate here.
                case (i_funct3)
                    F3_ADD:  o_alucc = OPCODE_LENGTH'(ALUCC_ADD);
                    F3_AND:  o_alucc = OPCODE_LENGTH'(ALUCC_AND);
                    F3_OR:   o_alucc = OPCODE_LENGTH'(ALUCC_OR);
                    default: o_illegal = 1'b1;
                endcase
            end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes ALU control, selects SrcB and buffers beats in a
// main + skid register pair so EX back-pressure never drops or reorders a beat.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_rs1_data,
    input  logic [DATA_WIDTH-1:0]    in_rs2_data,
    input  logic [DATA_WIDTH-1:0]    in_imm,
    input  logic                     in_alu_src,
    input  logic [1:0]               in_alu_op,
    input  logic [2:0]               in_funct3,
    input  logic [6:0]               in_funct7,
    input  logic [REG_ADDR_W-1:0]    in_rd,
    input  logic                     in_reg_write,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_WIDTH-1:0]    out_srca,
    output logic [DATA_WIDTH-1:0]    out_srcb,
    output logic [OPCODE_LENGTH-1:0] out_alucc,
    output logic [REG_ADDR_W-1:0]    out_rd,
    output logic                     out_reg_write,
    output logic                     out_illegal
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0]    srca;
        logic [DATA_WIDTH-1:0]    srcb;
        logic [OPCODE_LENGTH-1:0] alucc;
        logic [REG_ADDR_W-1:0]    rd;
        logic                     reg_write;
        logic                     illegal;
    } beat_t;

    localparam beat_t RESET_BEAT = '{
        srca:      '0,
        srcb:      '0,
        alucc:     OPCODE_LENGTH'(ALUCC_ADD),
        rd:        '0,
        reg_write: 1'b0,
        illegal:   1'b0
    };

    logic                     r_main_valid;
    logic                     r_skid_valid;
    beat_t                    r_main;
    beat_t                    r_skid;
    beat_t                    w_in_beat;
    logic [OPCODE_LENGTH-1:0] w_alucc;
    logic                     w_illegal;
    logic                     w_accept;
    logic                     w_drain;
    logic                     w_unused_f7;

    assign w_unused_f7 = ^{in_funct7[6], in_funct7[4:0]};

    alu_ctrl_decode #(
        .OPCODE_LENGTH(OPCODE_LENGTH)
    ) u_decode (
        .i_alu_op   (in_alu_op),
        .i_funct3   (in_funct3),
        .i_funct7_b5(in_funct7[5]),
        .o_alucc    (w_alucc),
        .o_illegal  (w_illegal)
    );

    always_comb begin
        w_in_beat           = RESET_BEAT;
        w_in_beat.srca      = in_rs1_data;
        w_in_beat.srcb      = in_alu_src ? in_imm : in_rs2_data;
        w_in_beat.alucc     = w_alucc;
        w_in_beat.rd        = in_rd;
        w_in_beat.reg_write = in_reg_write & ~w_illegal;
        w_in_beat.illegal   = w_illegal;
    end

    // Handshake: a beat moves on a side only in a cycle where that side's valid and
    // ready are both high. in_ready is purely registered (skid empty), out_valid is
    // the main-entry flag, and the main data never changes while out_valid & !out_ready.
    assign in_ready = ~r_skid_valid;
    assign w_accept = in_valid & in_ready;
    assign w_drain  = r_main_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= RESET_BEAT;
            r_skid       <= RESET_BEAT;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (r_skid_valid) begin
            // Skid full means in_ready is low, so only a drain can happen here.
            if (w_drain) begin
                r_main       <= r_skid;
                r_skid_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_main_valid || w_drain) begin
                r_main       <= w_in_beat;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_in_beat;
                r_skid_valid <= 1'b1;
            end
        end else if (w_drain) begin
            r_main_valid <= 1'b0;
        end
    end

    assign out_valid     = r_main_valid;
    assign out_srca      = r_main.srca;
    assign out_srcb      = r_main.srcb;
    assign out_alucc     = r_main.alucc;
    assign out_rd        = r_main.rd;
    assign out_reg_write = r_main.reg_write;
    assign out_illegal   = r_main.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, SrcB select, skid back-pressure,
// flush and asynchronous reset, with hand-computed expectations.
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_rs1_data;
    logic [63:0] in_rs2_data;
    logic [63:0] in_imm;
    logic        in_alu_src;
    logic [1:0]  in_alu_op;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_srca;
    logic [63:0] out_srcb;
    logic [3:0]  out_alucc;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic        out_illegal;

    int total;
    int bad;

    alu_issue_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_rs1_data  (in_rs1_data),
        .in_rs2_data  (in_rs2_data),
        .in_imm       (in_imm),
        .in_alu_src   (in_alu_src),
        .in_alu_op    (in_alu_op),
        .in_funct3    (in_funct3),
        .in_funct7    (in_funct7),
        .in_rd        (in_rd),
        .in_reg_write (in_reg_write),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_srca     (out_srca),
        .out_srcb     (out_srcb),
        .out_alucc    (out_alucc),
        .out_rd       (out_rd),
        .out_reg_write(out_reg_write),
        .out_illegal  (out_illegal)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] rs1, input logic [63:0] rs2,
                         input logic [63:0] imm, input logic src,
                         input logic [1:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd,
                         input logic rw);
        in_valid     = 1'b1;
        in_rs1_data  = rs1;
        in_rs2_data  = rs2;
        in_imm       = imm;
        in_alu_src   = src;
        in_alu_op    = op;
        in_funct3    = f3;
        in_funct7    = f7;
        in_rd        = rd;
        in_reg_write = rw;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        rst_n        = 1'b0;
        flush        = 1'b0;
        in_valid     = 1'b0;
        in_rs1_data  = '0;
        in_rs2_data  = '0;
        in_imm       = '0;
        in_alu_src   = 1'b0;
        in_alu_op    = 2'b00;
        in_funct3    = 3'b000;
        in_funct7    = 7'b0;
        in_rd        = 5'd0;
        in_reg_write = 1'b0;
        out_ready    = 1'b0;

        // 1: reset then idle
        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_alucc", 64'(out_alucc), 64'h2);
        chk("rst_srca", out_srca, 64'd0);
        chk("rst_reg_write", 64'(out_reg_write), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_out_valid", 64'(out_valid), 64'd0);

        // 2: R-type SUB, one-cycle latency
        out_ready = 1'b1;
        drive(64'd10, 64'd3, 64'h55, 1'b0, 2'b10, 3'b000, 7'b0100000, 5'd5, 1'b1);
        tick();
        chk("sub_valid", 64'(out_valid), 64'd1);
        chk("sub_srca", out_srca, 64'd10);
        chk("sub_srcb", out_srcb, 64'd3);
        chk("sub_alucc", 64'(out_alucc), 64'h6);
        chk("sub_rd", 64'(out_rd), 64'd5);
        chk("sub_rw", 64'(out_reg_write), 64'd1);
        chk("sub_illegal", 64'(out_illegal), 64'd0);

        // 3: I-type ORI back to back, SrcB from immediate
        drive(64'h1234, 64'd99, 64'hF0, 1'b1, 2'b11, 3'b110, 7'b0, 5'd6, 1'b1);
        tick();
        chk("ori_valid", 64'(out_valid), 64'd1);
        chk("ori_srca", out_srca, 64'h1234);
        chk("ori_srcb", out_srcb, 64'hF0);
        chk("ori_alucc", 64'(out_alucc), 64'h1);

        // decode table sweep through the pipe
        drive(64'd1, 64'd2, 64'd7, 1'b1, 2'b11, 3'b000, 7'b0100000, 5'd7, 1'b1);
        tick();
        chk("addi_f7_ignored", 64'(out_alucc), 64'h2);
        chk("addi_srcb", out_srcb, 64'd7);
        drive(64'd1, 64'd2, 64'd7, 1'b0, 2'b10, 3'b111, 7'b0, 5'd8, 1'b1);
        tick();
        chk("and_alucc", 64'(out_alucc), 64'h0);
        chk("and_srcb", out_srcb, 64'd2);
        drive(64'd1, 64'd2, 64'd7, 1'b0, 2'b10, 3'b000, 7'b0, 5'd9, 1'b1);
        tick();
        chk("add_alucc", 64'(out_alucc), 64'h2);
        drive(64'd1, 64'd2, 64'd7, 1'b1, 2'b00, 3'b011, 7'b0, 5'd9, 1'b1);
        tick();
        chk("ldst_alucc", 64'(out_alucc), 64'h2);
        chk("ldst_illegal", 64'(out_illegal), 64'd0);
        drive(64'd1, 64'd2, 64'd7, 1'b0, 2'b01, 3'b001, 7'b0, 5'd0, 1'b0);
        tick();
        chk("br_alucc", 64'(out_alucc), 64'h6);
        in_valid = 1'b0;
        tick();
        chk("drained_valid", 64'(out_valid), 64'd0);

        // 4: back-pressure fills skid, then drains in order
        out_ready = 1'b0;
        drive(64'hA, 64'd1, 64'd0, 1'b0, 2'b10, 3'b000, 7'b0, 5'd10, 1'b1);
        tick();
        chk("bp_a_valid", 64'(out_valid), 64'd1);
        chk("bp_a_ready", 64'(in_ready), 64'd1);
        drive(64'hB, 64'd2, 64'd0, 1'b0, 2'b10, 3'b111, 7'b0, 5'd11, 1'b1);
        tick();
        chk("bp_hold_a", out_srca, 64'hA);
        chk("bp_skid_full", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        tick();
        chk("bp_still_a", out_srca, 64'hA);
        chk("bp_still_alucc", 64'(out_alucc), 64'h2);
        chk("bp_still_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        tick();
        chk("bp_b_valid", 64'(out_valid), 64'd1);
        chk("bp_b_srca", out_srca, 64'hB);
        chk("bp_b_alucc", 64'(out_alucc), 64'h0);
        chk("bp_b_rd", 64'(out_rd), 64'd11);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        chk("bp_empty", 64'(out_valid), 64'd0);

        // 5: flush with skid full and a beat offered
        out_ready = 1'b0;
        drive(64'hC, 64'd0, 64'd0, 1'b0, 2'b10, 3'b000, 7'b0, 5'd12, 1'b1);
        tick();
        drive(64'hD, 64'd0, 64'd0, 1'b0, 2'b10, 3'b000, 7'b0, 5'd13, 1'b1);
        tick();
        chk("fl_pre_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        drive(64'hE, 64'd0, 64'd0, 1'b0, 2'b10, 3'b000, 7'b0, 5'd14, 1'b1);
        tick();
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_ready", 64'(in_ready), 64'd1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_no_beat", 64'(out_valid), 64'd0);
        // flush drops a same-cycle accept into an empty stage
        flush = 1'b1;
        drive(64'hF, 64'd0, 64'd0, 1'b0, 2'b10, 3'b000, 7'b0, 5'd15, 1'b1);
        tick();
        chk("fl_drop_accept", 64'(out_valid), 64'd0);
        flush = 1'b0;
        in_valid = 1'b0;

        // 6: illegal decodes suppress writeback
        drive(64'd4, 64'd5, 64'd0, 1'b0, 2'b10, 3'b001, 7'b0, 5'd3, 1'b1);
        tick();
        chk("ill_r_valid", 64'(out_valid), 64'd1);
        chk("ill_r_alucc", 64'(out_alucc), 64'h2);
        chk("ill_r_flag", 64'(out_illegal), 64'd1);
        chk("ill_r_rw", 64'(out_reg_write), 64'd0);
        drive(64'd4, 64'd5, 64'd0, 1'b1, 2'b11, 3'b100, 7'b0, 5'd3, 1'b1);
        tick();
        chk("ill_i_flag", 64'(out_illegal), 64'd1);
        chk("ill_i_rw", 64'(out_reg_write), 64'd0);

        // asynchronous reset mid-stream with skid occupied
        out_ready = 1'b0;
        drive(64'h77, 64'd0, 64'd0, 1'b0, 2'b10, 3'b111, 7'b0, 5'd1, 1'b1);
        tick();
        drive(64'h88, 64'd0, 64'd0, 1'b0, 2'b10, 3'b110, 7'b0, 5'd2, 1'b1);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_srca", out_srca, 64'd0);
        chk("arst_alucc", 64'(out_alucc), 64'h2);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("arst_no_beat", 64'(out_valid), 64'd0);
        drive(64'h99, 64'd1, 64'd0, 1'b0, 2'b10, 3'b110, 7'b0, 5'd4, 1'b1);
        tick();
        chk("recover_srca", out_srca, 64'h99);
        chk("recover_alucc", 64'(out_alucc), 64'h1);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
